// File: rtl/systolic_sequencer.sv
// rtl/systolic_sequencer.sv - sequences one 2x2 matrix-multiply pass on the systolic array
module systolic_sequencer #(
  parameter int DATA_W       = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              keep_weights,
  input  logic              abort,
  input  logic [DATA_W-1:0] w11,
  input  logic [DATA_W-1:0] w12,
  input  logic [DATA_W-1:0] w21,
  input  logic [DATA_W-1:0] w22,
  input  logic [DATA_W-1:0] a11,
  input  logic [DATA_W-1:0] a12,
  input  logic [DATA_W-1:0] a21,
  input  logic [DATA_W-1:0] a22,
  output logic              load_weight,
  output logic [DATA_W-1:0] weight1,
  output logic [DATA_W-1:0] weight2,
  output logic [DATA_W-1:0] weight3,
  output logic [DATA_W-1:0] weight4,
  output logic              valid,
  output logic [DATA_W-1:0] a_in1,
  output logic [DATA_W-1:0] a_in2,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, LOAD_W, FEED0, FEED1, FEED2, DRAIN, DONE} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t            state, state_nxt;
  logic [3:0]        drain_cnt, drain_cnt_nxt;
  logic              accept;
  logic [DATA_W-1:0] la11, la12, la21, la22;
  logic [DATA_W-1:0] act11, act12, act21, act22;
  logic              load_nxt, valid_nxt, busy_nxt, done_nxt;
  logic [DATA_W-1:0] a_in1_nxt, a_in2_nxt;

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    accept        = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            accept    = 1'b1;
            state_nxt = keep_weights ? FEED0 : LOAD_W;
          end else begin
            state_nxt = IDLE;
          end
        end
        LOAD_W: state_nxt = FEED0;
        FEED0:  state_nxt = FEED1;
        FEED1:  state_nxt = FEED2;
        FEED2: begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = DRAIN_LOAD;
        end
        DRAIN: begin
          if (drain_cnt == 4'd0) state_nxt = DONE;
          else drain_cnt_nxt = drain_cnt - 4'd1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it
  always_comb begin
    act11     = accept ? a11 : la11;
    act12     = accept ? a12 : la12;
    act21     = accept ? a21 : la21;
    act22     = accept ? a22 : la22;
    load_nxt  = (state_nxt == LOAD_W);
    valid_nxt = (state_nxt == FEED0) || (state_nxt == FEED1) ||
                (state_nxt == FEED2) || (state_nxt == DRAIN);
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = (state_nxt == DONE);
    a_in1_nxt = '0;
    a_in2_nxt = '0;
    case (state_nxt)
      FEED0: a_in1_nxt = act11;
      FEED1: begin
        a_in1_nxt = act12;
        a_in2_nxt = act21;
      end
      FEED2: a_in2_nxt = act22;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      drain_cnt   <= '0;
      la11        <= '0;
      la12        <= '0;
      la21        <= '0;
      la22        <= '0;
      weight1     <= '0;
      weight2     <= '0;
      weight3     <= '0;
      weight4     <= '0;
      load_weight <= 1'b0;
      valid       <= 1'b0;
      a_in1       <= '0;
      a_in2       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      if (accept) begin
        la11    <= a11;
        la12    <= a12;
        la21    <= a21;
        la22    <= a22;
        weight1 <= w11;
        weight2 <= w12;
        weight3 <= w21;
        weight4 <= w22;
      end
      load_weight <= load_nxt;
      valid       <= valid_nxt;
      a_in1       <= a_in1_nxt;
      a_in2       <= a_in2_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// tb/tb_systolic_sequencer.sv - directed self-checking bench for systolic_sequencer
module tb_systolic_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, keep_weights, abort;
  logic [15:0] w11, w12, w21, w22, a11, a12, a21, a22;
  logic        load_weight, valid, busy, done;
  logic [15:0] weight1, weight2, weight3, weight4, a_in1, a_in2;
  logic [35:0] obs;
  int          checks = 0;
  int          errors = 0;

  // obs = {load_weight, valid, busy, done, a_in1, a_in2}
  assign obs = {load_weight, valid, busy, done, a_in1, a_in2};

  always #5 clk = ~clk;

  systolic_sequencer #(.DATA_W(16), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .start(start), .keep_weights(keep_weights), .abort(abort),
    .w11(w11), .w12(w12), .w21(w21), .w22(w22),
    .a11(a11), .a12(a12), .a21(a21), .a22(a22),
    .load_weight(load_weight), .weight1(weight1), .weight2(weight2), .weight3(weight3),
    .weight4(weight4), .valid(valid), .a_in1(a_in1), .a_in2(a_in2), .busy(busy), .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [15:0] b11, b12, b21, b22, c11, c12, c21, c22);
    w11 = b11; w12 = b12; w21 = b21; w22 = b22;
    a11 = c11; a12 = c12; a21 = c21; a22 = c22;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++;
    if ({obs, weight1, weight2, weight3, weight4} !== 100'd0) begin
      errors++;
      $display("FAIL reset: got obs=%h w=%h/%h/%h/%h expected all 0", obs, weight1, weight2, weight3, weight4);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_nominal();
    logic [35:0] exp_seq [0:8] = '{
      {4'b1010, 16'd0, 16'd0},  {4'b0110, 16'd11, 16'd0}, {4'b0110, 16'd12, 16'd21},
      {4'b0110, 16'd0, 16'd22}, {4'b0110, 16'd0, 16'd0},  {4'b0110, 16'd0, 16'd0},
      {4'b0110, 16'd0, 16'd0},  {4'b0011, 16'd0, 16'd0},  {4'b0000, 16'd0, 16'd0}};
    set_ops(3, 5, 4, 6, 11, 12, 21, 22);
    keep_weights = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    set_ops(99, 99, 99, 99, 77, 77, 77, 77);
    checks++;
    if ({weight1, weight2, weight3, weight4} !== {16'd3, 16'd5, 16'd4, 16'd6}) begin
      errors++;
      $display("FAIL nominal_weights: got %0d %0d %0d %0d expected 3 5 4 6", weight1, weight2, weight3, weight4);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs !== exp_seq[i]) begin
        errors++;
        $display("FAIL nominal cyc%0d: got %h expected %h", i + 1, obs, exp_seq[i]);
      end
      if (i < 8) step();
    end
  endtask

  task automatic test_keep_weights();
    logic [35:0] exp_seq [0:7] = '{
      {4'b0110, 16'd1, 16'd0}, {4'b0110, 16'd2, 16'd3}, {4'b0110, 16'd0, 16'd4},
      {4'b0110, 16'd0, 16'd0}, {4'b0110, 16'd0, 16'd0}, {4'b0110, 16'd0, 16'd0},
      {4'b0011, 16'd0, 16'd0}, {4'b0000, 16'd0, 16'd0}};
    set_ops(3, 5, 4, 6, 1, 2, 3, 4);
    keep_weights = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    keep_weights = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs !== exp_seq[i]) begin
        errors++;
        $display("FAIL keep_weights cyc%0d: got %h expected %h", i + 1, obs, exp_seq[i]);
      end
      if (i < 7) step();
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] exp_seq [0:16] = '{
      {4'b1010, 16'd0, 16'd0},  {4'b0110, 16'd11, 16'd0}, {4'b0110, 16'd12, 16'd21},
      {4'b0110, 16'd0, 16'd22}, {4'b0110, 16'd0, 16'd0},  {4'b0110, 16'd0, 16'd0},
      {4'b0110, 16'd0, 16'd0},  {4'b0011, 16'd0, 16'd0},
      {4'b1010, 16'd0, 16'd0},  {4'b0110, 16'd31, 16'd0}, {4'b0110, 16'd32, 16'd41},
      {4'b0110, 16'd0, 16'd42}, {4'b0110, 16'd0, 16'd0},  {4'b0110, 16'd0, 16'd0},
      {4'b0110, 16'd0, 16'd0},  {4'b0011, 16'd0, 16'd0},  {4'b0000, 16'd0, 16'd0}};
    set_ops(3, 5, 4, 6, 11, 12, 21, 22);
    keep_weights = 1'b0;
    start = 1'b1;
    step();
    set_ops(3, 5, 4, 6, 31, 32, 41, 42);
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (obs !== exp_seq[i]) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: got %h expected %h", i + 1, obs, exp_seq[i]);
      end
      if (i == 15) start = 1'b0;
      if (i < 16) step();
    end
  endtask

  task automatic test_start_ignored();
    logic [35:0] exp_seq [0:9] = '{
      {4'b1010, 16'd0, 16'd0}, {4'b0110, 16'd5, 16'd0}, {4'b0110, 16'd6, 16'd7},
      {4'b0110, 16'd0, 16'd8}, {4'b0110, 16'd0, 16'd0}, {4'b0110, 16'd0, 16'd0},
      {4'b0110, 16'd0, 16'd0}, {4'b0011, 16'd0, 16'd0}, {4'b0000, 16'd0, 16'd0},
      {4'b0000, 16'd0, 16'd0}};
    set_ops(1, 1, 1, 1, 5, 6, 7, 8);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs !== exp_seq[i]) begin
        errors++;
        $display("FAIL start_ignored cyc%0d: got %h expected %h", i + 1, obs, exp_seq[i]);
      end
      // pulse start while in FEED1 (i=2) and in DRAIN (i=5)
      start = (i == 2 || i == 5);
      if (i < 9) step();
    end
    start = 1'b0;
  endtask

  task automatic test_abort();
    logic [35:0] exp_seq [0:8] = '{
      {4'b1010, 16'd0, 16'd0},  {4'b0110, 16'd11, 16'd0}, {4'b0110, 16'd12, 16'd21},
      {4'b0110, 16'd0, 16'd22}, {4'b0110, 16'd0, 16'd0},  {4'b0110, 16'd0, 16'd0},
      {4'b0110, 16'd0, 16'd0},  {4'b0011, 16'd0, 16'd0},  {4'b0000, 16'd0, 16'd0}};
    set_ops(2, 2, 2, 2, 9, 9, 9, 9);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if (obs !== {4'b0110, 16'd9, 16'd9}) begin
      errors++;
      $display("FAIL abort_pre: got %h expected %h", obs, {4'b0110, 16'd9, 16'd9});
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs !== 36'd0) begin
        errors++;
        $display("FAIL abort_idle cyc%0d: got %h expected 0", i, obs);
      end
      step();
    end
    set_ops(3, 5, 4, 6, 11, 12, 21, 22);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs !== exp_seq[i]) begin
        errors++;
        $display("FAIL abort_rerun cyc%0d: got %h expected %h", i + 1, obs, exp_seq[i]);
      end
      if (i < 8) step();
    end
  endtask

  task automatic test_done_abort_priority();
    set_ops(1, 1, 1, 1, 1, 2, 3, 4);
    keep_weights = 1'b1;
    start = 1'b1;
    step();
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (obs !== {4'b0011, 16'd0, 16'd0}) begin
      errors++;
      $display("FAIL prio_done: got %h expected %h", obs, {4'b0011, 16'd0, 16'd0});
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    keep_weights = 1'b0;
    checks++;
    if (obs !== 36'd0) begin
      errors++;
      $display("FAIL prio_abort_wins: got %h expected 0", obs);
    end
    step();
  endtask

  task automatic test_reset_mid_pass();
    set_ops(7, 8, 9, 10, 1, 2, 3, 4);
    keep_weights = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    keep_weights = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (obs !== {4'b0110, 16'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_mid_pre: got %h expected %h", obs, {4'b0110, 16'd0, 16'd0});
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++;
    if ({obs, weight1, weight2, weight3, weight4} !== 100'd0) begin
      errors++;
      $display("FAIL reset_mid_clear: got obs=%h w=%h/%h/%h/%h expected all 0", obs, weight1, weight2, weight3, weight4);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (obs !== 36'd0) begin
        errors++;
        $display("FAIL reset_mid_idle cyc%0d: got %h expected 0", i, obs);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    keep_weights = 1'b0;
    abort = 1'b0;
    set_ops(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_nominal();
    test_keep_weights();
    test_back_to_back();
    test_start_ignored();
    test_abort();
    test_done_abort_priority();
    test_reset_mid_pass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
